prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 28 ++
 rtl/word_assembler.sv | 53 +++++
 rtl/prog_loader.sv | 154 +++++++++++++++
 tb/tb_prog_loader.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared loader state encoding, memory depth and byte-lane helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } load_state_t;

    localparam int unsigned c_mem_words_default = 8192;
    localparam int unsigned c_byte_w            = 8;
    localparam int unsigned c_lanes             = 4;

    // Bit offset of the lane that receives the idx-th byte of a word.
    function automatic logic [4:0] lane_lsb(input logic [1:0] idx, input logic big_endian);
        return big_endian ? {~idx, 3'b000} : {idx, 3'b000};
    endfunction

endpackage : prog_loader_pkg

`default_nettype wire

// File: rtl/word_assembler.sv
// ============================================================================
// Module      : word_assembler
// Description : Packs four stream bytes into a 32-bit word in the selected lane order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_assembler
    import prog_loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_next,
    output logic        last
);

    logic [31:0] r_word;
    logic [1:0]  r_cnt;
    logic [4:0]  w_lsb;

    assign w_lsb = lane_lsb(r_cnt, BIG_ENDIAN);
    assign last  = accept && (r_cnt == 2'(c_lanes - 1));

    // Word including the byte being accepted this cycle, so the FSM can
    // register the complete word on the same edge as the final byte.
    always_comb begin
        word_next = r_word;
        if (accept) begin
            word_next[w_lsb +: c_byte_w] = byte_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (accept) begin
            r_word <= word_next;
            r_cnt  <= r_cnt + 2'd1;
        end
    end

endmodule : word_assembler

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Streams bytes into instruction memory words, holding the CPU meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = c_mem_words_default,
    parameter bit          BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] base_addr,
    input  logic [13:0] word_count,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        write_en,
    output logic [31:0] write_address,
    output logic [31:0] instruc_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    load_state_t r_state;
    logic [31:0] r_addr;
    logic [13:0] r_remaining;
    logic        r_byte_ready;
    logic        r_write_en;
    logic [31:0] r_write_address;
    logic [31:0] r_instruc_data;
    logic        r_cpu_hold;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_clear;
    logic        w_last;
    logic [31:0] w_word_next;
    logic        w_in_range;
    logic        w_unused_base_lsbs;

    // byte_ready is high exactly while in COLLECT, so it doubles as the state test.
    assign w_accept           = r_byte_ready & byte_valid & ~abort;
    assign w_clear            = ~r_byte_ready | abort;
    assign w_in_range         = ({2'b00, r_addr[31:2]} < 32'(MEM_WORDS));
    assign w_unused_base_lsbs = ^base_addr[1:0];

    word_assembler #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_word_assembler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (w_clear),
        .accept    (w_accept),
        .byte_data (byte_data),
        .word_next (w_word_next),
        .last      (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_byte_ready    <= 1'b0;
            r_write_en      <= 1'b0;
            r_write_address <= '0;
            r_instruc_data  <= '0;
            r_cpu_hold      <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_write_en <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_addr      <= {base_addr[31:2], 2'b00};
                        r_remaining <= word_count;
                        r_err       <= 1'b0;
                        r_cpu_hold  <= 1'b1;
                        if (word_count == 14'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= ST_COLLECT;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (abort) begin
                        r_state      <= ST_IDLE;
                        r_byte_ready <= 1'b0;
                        r_cpu_hold   <= 1'b0;
                    end else if (w_last) begin
                        r_state         <= ST_WRITE;
                        r_byte_ready    <= 1'b0;
                        r_write_en      <= w_in_range;
                        r_write_address <= r_addr;
                        r_instruc_data  <= w_word_next;
                    end
                end
                ST_WRITE: begin
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_cpu_hold <= 1'b0;
                    end else if (!w_in_range) begin
                        r_state    <= ST_IDLE;
                        r_cpu_hold <= 1'b0;
                        r_err      <= 1'b1;
                    end else begin
                        r_addr      <= r_addr + 32'd4;
                        r_remaining <= r_remaining - 14'd1;
                        if (r_remaining == 14'd1) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= ST_COLLECT;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_cpu_hold <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                    r_cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready    = r_byte_ready;
    assign write_en      = r_write_en;
    assign write_address = r_write_address;
    assign instruc_data  = r_instruc_data;
    assign cpu_hold      = r_cpu_hold;
    assign done          = r_done;
    assign err           = r_err;

endmodule : prog_loader

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module      : tb_prog_loader
// Description : Randomized self-checking bench for prog_loader in both byte orders.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prog_loader;

    typedef logic [7:0] byte_q_t [$];
    localparam int unsigned c_mem_words = 8192;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, byte_valid;
    logic [31:0] base_addr;
    logic [13:0] word_count;
    logic [7:0]  byte_data;

    logic        byte_ready, write_en, cpu_hold, done, err;
    logic [31:0] write_address, instruc_data;
    logic        le_byte_ready, le_write_en, le_cpu_hold, le_done, le_err;
    logic [31:0] le_write_address, le_instruc_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_be_q [$];
    logic [31:0] wr_le_q [$];
    int          wr_cyc_q [$];
    int          acc4_q [$];
    int          le_wr_n, done_n, done_cyc;

    prog_loader #(.MEM_WORDS(8192), .BIG_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .write_en(write_en), .write_address(write_address), .instruc_data(instruc_data),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    prog_loader #(.MEM_WORDS(8192), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(le_byte_ready),
        .write_en(le_write_en), .write_address(le_write_address), .instruc_data(le_instruc_data),
        .cpu_hold(le_cpu_hold), .done(le_done), .err(le_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed memory traffic, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (write_en) begin
                wr_addr_q.push_back(write_address);
                wr_be_q.push_back(instruc_data);
                wr_le_q.push_back(le_instruc_data);
                wr_cyc_q.push_back(cyc);
            end
            if (le_write_en) le_wr_n++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run still active at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_be_q.delete();
        wr_le_q.delete();
        wr_cyc_q.delete();
        acc4_q.delete();
        le_wr_n = 0;
        done_n  = 0;
    endtask

    // Drives one load and checks it against a word-level model of the stream.
    task automatic run_load(input logic [31:0] base, input int count, input byte_q_t bytes,
                            input int gap_pct, input string name);
        logic [31:0] a0, a, exp_be, exp_le;
        int n_ok, n_feed, idx, guard;
        bit all_ok, rdy;
        a0 = {base[31:2], 2'b00};
        a = a0;
        n_ok = 0;
        all_ok = 1'b1;
        for (int k = 0; k < count; k++) begin
            if ((a >> 2) < c_mem_words) n_ok++;
            else begin
                all_ok = 1'b0;
                break;
            end
            a = a + 32'd4;
        end
        n_feed = all_ok ? count : n_ok + 1;
        clear_mon();

        start = 1'b1; base_addr = base; word_count = 14'(count);
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; word_count = 14'($urandom);
        total++;
        if (err !== 1'b0 || cpu_hold !== 1'b1)
            $display("FAIL %s start: err=%b cpu_hold=%b want err=0 cpu_hold=1", name, err, cpu_hold);
        if (err !== 1'b0 || cpu_hold !== 1'b1) bad++;

        idx = 0;
        guard = 0;
        while (idx < n_feed * 4 && guard < 4000) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b1;
                byte_data  = bytes[idx];
            end
            rdy = byte_ready;
            @(posedge clk); #1;
            guard++;
            if (byte_valid && rdy) begin
                idx++;
                if (idx % 4 == 0) acc4_q.push_back(cyc);
            end
        end
        byte_valid = 1'b0;
        total++;
        if (guard >= 4000) begin
            bad++;
            $display("FAIL %s feed: accepted %0d bytes want %0d", name, idx, n_feed * 4);
        end

        guard = 0;
        while (cpu_hold && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL %s hold_release: cpu_hold=%b want 0", name, cpu_hold);
        end

        total++;
        if (wr_addr_q.size() != n_ok || le_wr_n != n_ok) begin
            bad++;
            $display("FAIL %s write_count: be=%0d le=%0d want %0d", name, wr_addr_q.size(), le_wr_n, n_ok);
        end
        for (int k = 0; k < n_ok && k < wr_addr_q.size(); k++) begin
            exp_be = {bytes[4*k], bytes[4*k+1], bytes[4*k+2], bytes[4*k+3]};
            exp_le = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
            total++;
            if (wr_addr_q[k] !== a0 + 32'(4 * k)) begin
                bad++;
                $display("FAIL %s addr[%0d]: got %h want %h", name, k, wr_addr_q[k], a0 + 32'(4 * k));
            end
            total++;
            if (wr_be_q[k] !== exp_be || wr_le_q[k] !== exp_le) begin
                bad++;
                $display("FAIL %s data[%0d]: be=%h le=%h want be=%h le=%h",
                         name, k, wr_be_q[k], wr_le_q[k], exp_be, exp_le);
            end
            total++;
            if (k >= acc4_q.size() || wr_cyc_q[k] != acc4_q[k]) begin
                bad++;
                $display("FAIL %s latency[%0d]: write cycle %0d want accept cycle %0d",
                         name, k, wr_cyc_q[k], (k < acc4_q.size()) ? acc4_q[k] : -1);
            end
        end
        total++;
        if (done_n != (all_ok ? 1 : 0)) begin
            bad++;
            $display("FAIL %s done_count: got %0d want %0d", name, done_n, all_ok ? 1 : 0);
        end
        if (all_ok && wr_cyc_q.size() > 0) begin
            total++;
            if (done_cyc != wr_cyc_q[$] + 1) begin
                bad++;
                $display("FAIL %s done_timing: done cycle %0d want %0d", name, done_cyc, wr_cyc_q[$] + 1);
            end
        end
        total++;
        if (err !== !all_ok || le_err !== !all_ok) begin
            bad++;
            $display("FAIL %s err: be=%b le=%b want %b", name, err, le_err, !all_ok);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        base_addr = '0; word_count = '0; byte_data = '0;
        #2;
        total++;
        if ({byte_ready, write_en, cpu_hold, done, err, le_byte_ready, le_write_en, le_cpu_hold, le_done, le_err} !== 10'b0
            || write_address !== 32'h0 || instruc_data !== 32'h0 || le_instruc_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: ctl=%b addr=%h data=%h want all zero",
                     {byte_ready, write_en, cpu_hold, done, err}, write_address, instruc_data);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({byte_ready, write_en, cpu_hold, done, err} !== 5'b0) begin
            bad++;
            $display("FAIL idle_after_reset: ctl=%b want 00000", {byte_ready, write_en, cpu_hold, done, err});
        end
    endtask

    task automatic test_directed();
        byte_q_t q;
        q = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05};
        run_load(32'h0, 2, q, 0, "be_two_words");
        total++;
        if (wr_be_q.size() != 2 || wr_be_q[0] !== 32'h8C010004 || wr_be_q[1] !== 32'h20020005) begin
            bad++;
            $display("FAIL be_constants: n=%0d w0=%h w1=%h want 8c010004 20020005",
                     wr_be_q.size(), (wr_be_q.size() > 0) ? wr_be_q[0] : 32'h0,
                     (wr_be_q.size() > 1) ? wr_be_q[1] : 32'h0);
        end
        q = '{8'h04, 8'h00, 8'h01, 8'h8C};
        run_load(32'h10, 1, q, 60, "le_with_gaps");
        total++;
        if (wr_le_q.size() != 1 || wr_le_q[0] !== 32'h8C010004) begin
            bad++;
            $display("FAIL le_constant: n=%0d w0=%h want 8c010004",
                     wr_le_q.size(), (wr_le_q.size() > 0) ? wr_le_q[0] : 32'h0);
        end
    endtask

    task automatic test_count_zero();
        clear_mon();
        start = 1'b1; base_addr = $urandom; word_count = 14'd0;
        @(posedge clk); #1;
        start = 1'b0; word_count = 14'($urandom_range(1, 100));
        total++;
        if (done !== 1'b1 || cpu_hold !== 1'b1 || write_en !== 1'b0) begin
            bad++;
            $display("FAIL count0_pulse: done=%b hold=%b we=%b want 1 1 0", done, cpu_hold, write_en);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL count0_release: done=%b hold=%b want 0 0", done, cpu_hold);
        end
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (wr_addr_q.size() != 0 || done_n != 1) begin
            bad++;
            $display("FAIL count0_totals: writes=%0d dones=%0d want 0 1", wr_addr_q.size(), done_n);
        end
    endtask

    task automatic test_range_error();
        byte_q_t q;
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        run_load(32'h7FFC, 2, q, 20, "range_top");
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: err=%b want 1", err);
        end
        q.delete();
        for (int i = 0; i < 24; i++) q.push_back(8'($urandom));
        run_load(32'h7FF0 | 32'($urandom_range(0, 3)), 6, q, 30, "range_partial");
    endtask

    task automatic test_abort();
        byte_q_t q;
        int n, g;
        bit rdy;
        clear_mon();
        start = 1'b1; base_addr = 32'h100; word_count = 14'd2;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        g = 0;
        while (n < 2 && g < 20) begin
            byte_valid = 1'b1;
            byte_data  = 8'($urandom);
            rdy = byte_ready;
            @(posedge clk); #1;
            g++;
            if (rdy) n++;
        end
        abort = 1'b1; byte_valid = 1'b1; byte_data = 8'hEE;
        @(posedge clk); #1;
        abort = 1'b0; byte_valid = 1'b0;
        total++;
        if (cpu_hold !== 1'b0 || byte_ready !== 1'b0 || le_cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: hold=%b ready=%b want 0 0", cpu_hold, byte_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (wr_addr_q.size() != 0 || done_n != 0) begin
            bad++;
            $display("FAIL abort_quiet: writes=%0d dones=%0d want 0 0", wr_addr_q.size(), done_n);
        end
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(32'h40, 1, q, 0, "abort_reload");
        total++;
        if (wr_be_q.size() != 1 || wr_be_q[0] !== 32'h11223344) begin
            bad++;
            $display("FAIL abort_reload_word: n=%0d w0=%h want 11223344",
                     wr_be_q.size(), (wr_be_q.size() > 0) ? wr_be_q[0] : 32'h0);
        end
    endtask

    task automatic test_reset_mid();
        byte_q_t q;
        int g;
        start = 1'b1; base_addr = 32'h200; word_count = 14'd3;
        @(posedge clk); #1;
        start = 1'b0;
        g = 0;
        byte_valid = 1'b1; byte_data = 8'h5A;
        while (!byte_ready && g < 10) begin
            @(posedge clk); #1;
            g++;
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        total++;
        if ({byte_ready, write_en, cpu_hold, done, err, le_cpu_hold} !== 6'b0
            || write_address !== 32'h0 || instruc_data !== 32'h0 || le_instruc_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid: ctl=%b addr=%h data=%h want all zero",
                     {byte_ready, write_en, cpu_hold, done, err}, write_address, instruc_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        run_load(32'($urandom_range(0, 32'h1000)), 3, q, 25, "after_reset");
    endtask

    task automatic test_random();
        byte_q_t q;
        int count;
        for (int t = 0; t < 8; t++) begin
            q.delete();
            count = $urandom_range(1, 5);
            for (int i = 0; i < count * 4; i++) q.push_back(8'($urandom));
            run_load(32'($urandom_range(0, 32'h7000)), count, q, $urandom_range(0, 60), "random");
        end
    endtask

    task automatic test_back_to_back();
        byte_q_t q;
        for (int t = 0; t < 3; t++) begin
            q.delete();
            for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
            run_load(32'h3000 + 32'(t * 64), 2, q, 0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_count_zero();
        test_range_error();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prog_loader

`default_nettype wire
